// File: rtl/layer_buf_pkg.sv
// Per-layer feature-map geometry shared by the result store and its neighbours.
// Also holds the row-major coordinate-to-linear-index helper.
package layer_buf_pkg;

    localparam int LAYER_MAP_W  = 30;
    localparam int LAYER_MAP_H  = 30;
    localparam int LAYER_DATA_W = 128;

    typedef logic [LAYER_DATA_W-1:0] pixel_t;

    function automatic logic [31:0] lin_addr(input logic [15:0] row,
                                             input logic [15:0] col,
                                             input int          map_w);
        return 32'(row) * 32'(map_w) + 32'(col);
    endfunction

endpackage

// File: rtl/result_bank.sv
// One 1W1R synchronous-read feature-map bank; this is the SRAM macro swap point.
// Read latency 1 cycle; rdata holds between reads; no backpressure.
// Write and read ports are independent and never target the same entry in a cycle.
module result_bank #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 900,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/layer_result_pingpong_buf.sv
// Ping-pong feature-map store between two conv layers, addressed by (row, col).
// Read latency 1 cycle; writes gated by wr_ready, reads by rd_ready, misuse flagged in ovf_err.
// Bank ownership swaps on wr_done/rd_done pulses or, with AUTO_SWAP, after a full map of writes.
module layer_result_pingpong_buf
    import layer_buf_pkg::*;
#(
    parameter int DATA_W    = LAYER_DATA_W,
    parameter int MAP_W     = LAYER_MAP_W,
    parameter int MAP_H     = LAYER_MAP_H,
    parameter int AUTO_SWAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [15:0]       wr_row,
    input  logic [15:0]       wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [15:0]       rd_row,
    input  logic [15:0]       rd_col,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              addr_err,
    output logic              ovf_err
);

    localparam int DEPTH = MAP_W * MAP_H;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [15:0] MAP_W16 = 16'(MAP_W);
    localparam logic [15:0] MAP_H16 = 16'(MAP_H);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic              wr_ptr, rd_ptr;
    logic [1:0]        bank_full;
    logic [AW:0]       wr_cnt, wr_cnt_inc;
    logic              rd_zero_q, rd_sel_q;

    logic              wr_in_range, rd_in_range;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic              wr_accept, rd_accept;
    logic              auto_done, wr_complete, rd_complete;
    logic [DATA_W-1:0] bank_q [2];

    assign wr_ready = ~bank_full[wr_ptr];
    assign rd_ready = bank_full[rd_ptr];
    assign wr_bank  = wr_ptr;
    assign rd_bank  = rd_ptr;

    assign wr_in_range = (wr_row < MAP_H16) && (wr_col < MAP_W16);
    assign rd_in_range = (rd_row < MAP_H16) && (rd_col < MAP_W16);
    assign wr_addr     = AW'(lin_addr(wr_row, wr_col, MAP_W));
    assign rd_addr     = AW'(lin_addr(rd_row, rd_col, MAP_W));

    assign wr_accept   = wr_en & wr_ready & wr_in_range;
    assign rd_accept   = rd_en & rd_ready;
    assign wr_cnt_inc  = wr_cnt + 1'b1;
    assign auto_done   = (AUTO_SWAP != 0) && wr_accept && (wr_cnt_inc == DEPTH_C);
    assign wr_complete = (wr_done & wr_ready) | auto_done;
    assign rd_complete = rd_done & rd_ready;

    // When both sides complete together they always own different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            bank_full <= 2'b00;
            wr_cnt    <= '0;
            addr_err  <= 1'b0;
            ovf_err   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_zero_q <= 1'b1;
            rd_sel_q  <= 1'b0;
        end else begin
            if (wr_complete) begin
                bank_full[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
                wr_cnt            <= '0;
            end else if (wr_accept) begin
                wr_cnt <= wr_cnt_inc;
            end
            if (rd_complete) begin
                bank_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            if ((wr_en & ~wr_in_range) | (rd_en & ~rd_in_range)) begin
                addr_err <= 1'b1;
            end
            if ((wr_en & ~wr_ready) | (rd_en & ~rd_ready)) begin
                ovf_err <= 1'b1;
            end
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_zero_q <= ~rd_in_range;
                rd_sel_q  <= rd_ptr;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        result_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_bank (
            .clk    (clk),
            .we     (wr_accept & (wr_ptr == 1'(b))),
            .waddr  (wr_addr),
            .wdata  (wr_data),
            .re     (rd_accept & rd_in_range & (rd_ptr == 1'(b))),
            .raddr  (rd_addr),
            .rdata  (bank_q[b])
        );
    end

    // Bank outputs only change on a read of that bank, so this mux holds its value between reads.
    assign rd_data = rd_zero_q ? '0 : bank_q[rd_sel_q];

endmodule

// File: tb/tb_layer_result_pingpong_buf.sv
// Directed bench for layer_result_pingpong_buf: table of single-cycle vectors plus
// hand-written fill/swap/overflow/reset/auto-swap sequences on a 30x30 map.
module tb_layer_result_pingpong_buf;

    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          wr_en, wr_done, rd_en, rd_done;
    logic [15:0]   wr_row, wr_col, rd_row, rd_col;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_ready, rd_ready, rd_valid, wr_bank, rd_bank, addr_err, ovf_err;

    logic          a_wr_en, a_wr_done, a_rd_en, a_rd_done;
    logic [15:0]   a_wr_row, a_wr_col, a_rd_row, a_rd_col;
    logic [DW-1:0] a_wr_data, a_rd_data;
    logic          a_wr_ready, a_rd_ready, a_rd_valid, a_wr_bank, a_rd_bank, a_addr_err, a_ovf_err;

    layer_result_pingpong_buf #(.DATA_W(DW), .MAP_W(30), .MAP_H(30), .AUTO_SWAP(0)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .wr_done(wr_done), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_done(rd_done),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .addr_err(addr_err), .ovf_err(ovf_err)
    );

    layer_result_pingpong_buf #(.DATA_W(DW), .MAP_W(30), .MAP_H(30), .AUTO_SWAP(1)) dut_auto (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_col(a_wr_col), .wr_data(a_wr_data),
        .wr_done(a_wr_done), .wr_ready(a_wr_ready),
        .rd_en(a_rd_en), .rd_row(a_rd_row), .rd_col(a_rd_col), .rd_done(a_rd_done),
        .rd_ready(a_rd_ready), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .wr_bank(a_wr_bank), .rd_bank(a_rd_bank), .addr_err(a_addr_err), .ovf_err(a_ovf_err)
    );

    typedef struct {
        logic          rd_en;
        logic [15:0]   rd_row;
        logic [15:0]   rd_col;
        logic          wr_en;
        logic [15:0]   wr_row;
        logic [15:0]   wr_col;
        logic          exp_vld;
        logic [DW-1:0] exp_dat;
        logic          exp_aerr;
    } vec_t;

    vec_t vt [7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        wr_row = 0; wr_col = 0; rd_row = 0; rd_col = 0; wr_data = '0;
        a_wr_en = 0; a_wr_done = 0; a_rd_en = 0; a_rd_done = 0;
        a_wr_row = 0; a_wr_col = 0; a_rd_row = 0; a_rd_col = 0; a_wr_data = '0;
    endtask

    task automatic fill(input int base, input bit done_last);
        for (int i = 0; i < 900; i++) begin
            wr_en   = 1'b1;
            wr_row  = 16'(i / 30);
            wr_col  = 16'(i % 30);
            wr_data = DW'(base + i);
            wr_done = done_last && (i == 899);
            step();
        end
        idle();
    endtask

    task automatic rd_at(input int row, input int col);
        rd_en = 1'b1; rd_row = 16'(row); rd_col = 16'(col);
        step();
        idle();
    endtask

    initial begin
        int bad;

        vt[0] = '{1'b1, 16'd2,  16'd5,  1'b0, 16'd0,  16'd0, 1'b1, DW'(65),  1'b0};
        vt[1] = '{1'b0, 16'd0,  16'd0,  1'b0, 16'd0,  16'd0, 1'b0, DW'(65),  1'b0};
        vt[2] = '{1'b1, 16'd29, 16'd29, 1'b0, 16'd0,  16'd0, 1'b1, DW'(899), 1'b0};
        vt[3] = '{1'b1, 16'd0,  16'd1,  1'b0, 16'd0,  16'd0, 1'b1, DW'(1),   1'b0};
        vt[4] = '{1'b1, 16'd0,  16'd30, 1'b0, 16'd0,  16'd0, 1'b1, DW'(0),   1'b1};
        vt[5] = '{1'b0, 16'd0,  16'd0,  1'b1, 16'd30, 16'd0, 1'b0, DW'(0),   1'b1};
        vt[6] = '{1'b1, 16'd10, 16'd3,  1'b0, 16'd0,  16'd0, 1'b1, DW'(303), 1'b1};

        idle();
        rst = 1'b1;
        step();
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data",  rd_data,  0);
        check("rst_banks",    {wr_bank, rd_bank}, 0);
        check("rst_errs",     {addr_err, ovf_err}, 0);
        rst = 1'b0;
        step();

        // Read before any bank is complete: no data, overflow flagged.
        rd_at(0, 0);
        check("early_rd_valid", rd_valid, 0);
        check("early_rd_ovf",   ovf_err,  1);
        rst = 1'b1; #1;
        check("rst_clears_ovf", ovf_err, 0);
        step();
        rst = 1'b0;
        step();

        fill(0, 1'b1);
        check("fill0_rd_ready", rd_ready, 1);
        check("fill0_wr_bank",  wr_bank,  1);
        check("fill0_wr_ready", wr_ready, 1);
        check("fill0_rd_bank",  rd_bank,  0);

        for (int i = 0; i < 7; i++) begin
            rd_en  = vt[i].rd_en;  rd_row = vt[i].rd_row; rd_col = vt[i].rd_col;
            wr_en  = vt[i].wr_en;  wr_row = vt[i].wr_row; wr_col = vt[i].wr_col;
            wr_data = DW'(16'hdead);
            step();
            check($sformatf("vec%0d_vld", i),  rd_valid, vt[i].exp_vld);
            check($sformatf("vec%0d_dat", i),  rd_data,  vt[i].exp_dat);
            check($sformatf("vec%0d_aerr", i), addr_err, vt[i].exp_aerr);
            check($sformatf("vec%0d_ovf", i),  ovf_err,  0);
        end
        idle();
        check("oor_write_dropped_cnt", dut.wr_cnt, 0);

        // Fill bank 1 while streaming bank 0 out; both done pulses land on the last cycle.
        bad = 0;
        for (int i = 0; i < 900; i++) begin
            wr_en = 1'b1; wr_row = 16'(i / 30); wr_col = 16'(i % 30); wr_data = DW'(1000 + i);
            rd_en = 1'b1; rd_row = 16'(i / 30); rd_col = 16'(i % 30);
            wr_done = (i == 899);
            rd_done = (i == 899);
            step();
            if (rd_valid !== 1'b1 || rd_data !== DW'(i)) bad++;
        end
        idle();
        check("pingpong_reads_bad", bad, 0);
        check("swap_rd_bank",  rd_bank,  1);
        check("swap_wr_bank",  wr_bank,  0);
        check("swap_rd_ready", rd_ready, 1);
        check("swap_wr_ready", wr_ready, 1);
        rd_at(2, 5);
        check("bank1_r2c5", rd_data, 1065);
        rd_at(29, 29);
        check("bank1_r29c29", rd_data, 1899);

        fill(2000, 1'b1);
        check("both_full_wr_ready", wr_ready, 0);
        check("both_full_rd_ready", rd_ready, 1);
        wr_en = 1'b1; wr_row = 0; wr_col = 0; wr_data = DW'(16'hbad);
        step();
        idle();
        check("full_wr_ovf",     ovf_err, 1);
        check("full_wr_bank",    wr_bank, 1);
        rd_at(0, 0);
        check("full_wr_dropped", rd_data, 1000);
        rd_done = 1'b1;
        step();
        idle();
        check("rd_done_rd_bank",  rd_bank,  0);
        check("rd_done_wr_ready", wr_ready, 1);
        rd_at(0, 0);
        check("bank0_refill_r0c0", rd_data, 2000);

        for (int i = 0; i < 400; i++) begin
            wr_en = 1'b1; wr_row = 16'(i / 30); wr_col = 16'(i % 30); wr_data = DW'(3000 + i);
            rd_en = 1'b1; rd_row = 16'(i / 30); rd_col = 16'(i % 30);
            step();
        end
        check("pre_rst_rd_valid", rd_valid, 1);
        check("pre_rst_rd_data",  rd_data,  2399);
        idle();
        rst = 1'b1; #1;
        check("mid_rst_wr_ready", wr_ready, 1);
        check("mid_rst_rd_ready", rd_ready, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_errs",     {addr_err, ovf_err}, 0);
        check("mid_rst_banks",    {wr_bank, rd_bank}, 0);
        check("mid_rst_wr_cnt",   dut.wr_cnt, 0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 900; i++) begin
            a_wr_en = 1'b1; a_wr_row = 16'(i / 30); a_wr_col = 16'(i % 30); a_wr_data = DW'(i);
            if (i == 899) check("auto_pre_rd_ready", a_rd_ready, 0);
            step();
        end
        idle();
        check("auto_rd_ready", a_rd_ready, 1);
        check("auto_wr_bank",  a_wr_bank,  1);
        check("auto_wr_cnt",   dut_auto.wr_cnt, 0);
        a_rd_en = 1'b1; a_rd_row = 2; a_rd_col = 5;
        step();
        idle();
        check("auto_rd_valid", a_rd_valid, 1);
        check("auto_rd_data",  a_rd_data,  65);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
